prefetch_cache_ctrl_nway: RTL and testbench

Control FSM for the next-generation prefetch cache, generalised from 2-way to NUM_WAYS-way set associativity.

---
 rtl/prefetch_cache_pkg.sv | 20 ++
 rtl/prefetch_cache_ctrl_nway_if.sv | 47 ++++
 rtl/way_onehot_dec.sv | 13 +
 rtl/prefetch_cache_ctrl_nway.sv | 141 ++++++++++++++
 tb/tb_prefetch_cache_ctrl_nway.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_cache_pkg.sv
// Shared types and encodings for the N-way prefetch cache controller.
package prefetch_cache_pkg;

    typedef enum logic [2:0] {
        CHECK    = 3'd0,
        WB       = 3'd1,
        FILL     = 3'd2,
        PF_CHECK = 3'd3,
        PF_WB    = 3'd4,
        PF_FILL  = 3'd5
    } ctrl_state_t;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LINE = 2'b01;
    localparam logic [1:0] WE_CPU  = 2'b10;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_PF  = 1'b1;

endpackage

// File: rtl/prefetch_cache_ctrl_nway_if.sv
// Bus between the cache controller and the CPU side, prefetcher, pmem adapter and datapath.
interface prefetch_cache_ctrl_nway_if #(
    parameter int NUM_WAYS = 4
) ();
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                mem_read;
    logic                mem_write;
    logic                mem_resp;
    logic                pf_req;
    logic                pf_ack;
    logic                pf_done;
    logic                pmem_resp;
    logic                pmem_read;
    logic                pmem_write;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim_way;
    logic                victim_dirty;
    logic                addr_src;
    logic                pmem_addr_sel;
    logic                data_in_sel;
    logic [NUM_WAYS-1:0] data_we;
    logic [1:0]          data_we_mode;
    logic [NUM_WAYS-1:0] ld_tag;
    logic [NUM_WAYS-1:0] ld_valid;
    logic [NUM_WAYS-1:0] ld_dirty;
    logic                valid_in;
    logic                dirty_in;
    logic                ld_lru;
    logic [WAY_W-1:0]    lru_way;

    modport master (
        input  mem_read, mem_write, pf_req, pmem_resp, hit, hit_way, victim_way, victim_dirty,
        output mem_resp, pf_ack, pf_done, pmem_read, pmem_write, addr_src, pmem_addr_sel,
               data_in_sel, data_we, data_we_mode, ld_tag, ld_valid, ld_dirty,
               valid_in, dirty_in, ld_lru, lru_way
    );

    modport slave (
        output mem_read, mem_write, pf_req, pmem_resp, hit, hit_way, victim_way, victim_dirty,
        input  mem_resp, pf_ack, pf_done, pmem_read, pmem_write, addr_src, pmem_addr_sel,
               data_in_sel, data_we, data_we_mode, ld_tag, ld_valid, ld_dirty,
               valid_in, dirty_in, ld_lru, lru_way
    );

endinterface

// File: rtl/way_onehot_dec.sv
// Way index to one-hot decoder; a shift keeps every in-range index X-free.
module way_onehot_dec #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic                en,
    input  logic [WAY_W-1:0]    idx,
    output logic [NUM_WAYS-1:0] onehot
);

    assign onehot = en ? (NUM_WAYS'(1) << idx) : '0;

endmodule

// File: rtl/prefetch_cache_ctrl_nway.sv
// N-way cache control FSM with demand and prefetch request sources; demand has priority.
module prefetch_cache_ctrl_nway
    import prefetch_cache_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter bit PF_UPDATE_LRU = 1'b0,
    localparam int WAY_W        = $clog2(NUM_WAYS)
) (
    input  logic                       clk,
    input  logic                       rst,
    prefetch_cache_ctrl_nway_if.master bus
);

    ctrl_state_t      state, state_next;
    logic [WAY_W-1:0] vreg, vreg_next;

    logic             we_en, tag_en, valid_en, dirty_en;
    logic [WAY_W-1:0] we_idx, dirty_idx;
    logic             demand;

    assign demand = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CHECK;
            vreg  <= '0;
        end else begin
            state <= state_next;
            vreg  <= vreg_next;
        end
    end

    // Mealy outputs so a demand hit completes in the cycle it is presented; reset forces idle values.
    always_comb begin
        state_next         = state;
        vreg_next          = vreg;
        bus.mem_resp       = 1'b0;
        bus.pf_ack         = 1'b0;
        bus.pf_done        = 1'b0;
        bus.pmem_read      = 1'b0;
        bus.pmem_write     = 1'b0;
        bus.addr_src       = SRC_CPU;
        bus.pmem_addr_sel  = 1'b1;
        bus.data_in_sel    = 1'b1;
        bus.data_we_mode   = WE_NONE;
        bus.valid_in       = 1'b0;
        bus.dirty_in       = 1'b0;
        bus.ld_lru         = 1'b0;
        bus.lru_way        = '0;
        we_en              = 1'b0;
        we_idx             = vreg;
        tag_en             = 1'b0;
        valid_en           = 1'b0;
        dirty_en           = 1'b0;
        dirty_idx          = vreg;
        if (!rst) begin
            case (state)
                CHECK: begin
                    if (demand) begin
                        if (bus.hit) begin
                            bus.mem_resp = 1'b1;
                            bus.ld_lru   = 1'b1;
                            bus.lru_way  = bus.hit_way;
                            if (bus.mem_write) begin
                                we_en            = 1'b1;
                                we_idx           = bus.hit_way;
                                bus.data_we_mode = WE_CPU;
                                dirty_en         = 1'b1;
                                dirty_idx        = bus.hit_way;
                                bus.dirty_in     = 1'b1;
                            end
                        end else begin
                            vreg_next  = bus.victim_way;
                            state_next = bus.victim_dirty ? WB : FILL;
                        end
                    end else if (bus.pf_req) begin
                        state_next = PF_CHECK;
                    end
                end
                PF_CHECK: begin
                    bus.addr_src = SRC_PF;
                    bus.pf_ack   = 1'b1;
                    if (bus.hit) begin
                        state_next = CHECK;
                    end else begin
                        vreg_next  = bus.victim_way;
                        state_next = bus.victim_dirty ? PF_WB : PF_FILL;
                    end
                end
                WB, PF_WB: begin
                    bus.addr_src      = (state == PF_WB) ? SRC_PF : SRC_CPU;
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = 1'b0;
                    if (bus.pmem_resp) begin
                        dirty_en   = 1'b1;
                        state_next = (state == PF_WB) ? PF_FILL : FILL;
                    end
                end
                FILL, PF_FILL: begin
                    bus.addr_src    = (state == PF_FILL) ? SRC_PF : SRC_CPU;
                    bus.pmem_read   = 1'b1;
                    bus.data_in_sel = 1'b0;
                    if (bus.pmem_resp) begin
                        we_en            = 1'b1;
                        bus.data_we_mode = WE_LINE;
                        tag_en           = 1'b1;
                        valid_en         = 1'b1;
                        bus.valid_in     = 1'b1;
                        dirty_en         = 1'b1;
                        state_next       = CHECK;
                        if (state == PF_FILL) begin
                            bus.pf_done = 1'b1;
                            if (PF_UPDATE_LRU) begin
                                bus.ld_lru  = 1'b1;
                                bus.lru_way = vreg;
                            end
                        end
                    end
                end
                default: state_next = CHECK;
            endcase
        end
    end

    way_onehot_dec #(.NUM_WAYS(NUM_WAYS)) u_dec_we (
        .en(we_en), .idx(we_idx), .onehot(bus.data_we)
    );

    way_onehot_dec #(.NUM_WAYS(NUM_WAYS)) u_dec_tag (
        .en(tag_en), .idx(vreg), .onehot(bus.ld_tag)
    );

    way_onehot_dec #(.NUM_WAYS(NUM_WAYS)) u_dec_valid (
        .en(valid_en), .idx(vreg), .onehot(bus.ld_valid)
    );

    way_onehot_dec #(.NUM_WAYS(NUM_WAYS)) u_dec_dirty (
        .en(dirty_en), .idx(dirty_idx), .onehot(bus.ld_dirty)
    );

endmodule

// File: tb/tb_prefetch_cache_ctrl_nway.sv
// Directed bench: 4-way (both PF_UPDATE_LRU settings) and 8-way controllers driven in lockstep.
module tb_prefetch_cache_ctrl_nway;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write, pf_req, pmem_resp, hit, victim_dirty;
    logic [3:0] hit_way, victim_way;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prefetch_cache_ctrl_nway_if #(.NUM_WAYS(4)) bus4  ();
    prefetch_cache_ctrl_nway_if #(.NUM_WAYS(4)) bus4u ();
    prefetch_cache_ctrl_nway_if #(.NUM_WAYS(8)) bus8  ();

    // Same stimulus fans out to all three instances.
    assign bus4.mem_read      = mem_read;
    assign bus4.mem_write     = mem_write;
    assign bus4.pf_req        = pf_req;
    assign bus4.pmem_resp     = pmem_resp;
    assign bus4.hit           = hit;
    assign bus4.hit_way       = hit_way[1:0];
    assign bus4.victim_way    = victim_way[1:0];
    assign bus4.victim_dirty  = victim_dirty;
    assign bus4u.mem_read     = mem_read;
    assign bus4u.mem_write    = mem_write;
    assign bus4u.pf_req       = pf_req;
    assign bus4u.pmem_resp    = pmem_resp;
    assign bus4u.hit          = hit;
    assign bus4u.hit_way      = hit_way[1:0];
    assign bus4u.victim_way   = victim_way[1:0];
    assign bus4u.victim_dirty = victim_dirty;
    assign bus8.mem_read      = mem_read;
    assign bus8.mem_write     = mem_write;
    assign bus8.pf_req        = pf_req;
    assign bus8.pmem_resp     = pmem_resp;
    assign bus8.hit           = hit;
    assign bus8.hit_way       = hit_way[2:0];
    assign bus8.victim_way    = victim_way[2:0];
    assign bus8.victim_dirty  = victim_dirty;

    prefetch_cache_ctrl_nway #(.NUM_WAYS(4), .PF_UPDATE_LRU(1'b0)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.master)
    );
    prefetch_cache_ctrl_nway #(.NUM_WAYS(4), .PF_UPDATE_LRU(1'b1)) dut4u (
        .clk(clk), .rst(rst), .bus(bus4u.master)
    );
    prefetch_cache_ctrl_nway #(.NUM_WAYS(8), .PF_UPDATE_LRU(1'b0)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.master)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic pf, input logic presp,
                                 input logic h, input logic [3:0] hw, input logic [3:0] vw,
                                 input logic vd);
        mem_read     = rd;
        mem_write    = wr;
        pf_req       = pf;
        pmem_resp    = presp;
        hit          = h;
        hit_way      = hw;
        victim_way   = vw;
        victim_dirty = vd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 1, 4'd2, 4'd0, 0);
        tick();
        checkOutput("rst_mem_resp", bus4.mem_resp, 0);
        checkOutput("rst_ld_lru", bus4.ld_lru, 0);
        checkOutput("rst_data_in_sel", bus4.data_in_sel, 1);
        checkOutput("rst_pmem_addr_sel", bus4.pmem_addr_sel, 1);
        checkOutput("rst_pmem_read", bus4.pmem_read, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0);
        tick();

        // Read hit way 2
        applyStimulus(1, 0, 0, 0, 1, 4'd2, 4'd0, 0);
        checkOutput("rh_mem_resp", bus4.mem_resp, 1);
        checkOutput("rh_ld_lru", bus4.ld_lru, 1);
        checkOutput("rh_lru_way", bus4.lru_way, 2);
        checkOutput("rh_ld_dirty", bus4.ld_dirty, 0);
        checkOutput("rh_data_we", bus4.data_we, 0);
        checkOutput("rh8_lru_way", bus8.lru_way, 2);
        tick();

        // Write miss, dirty victim 3
        applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd3, 1);
        checkOutput("wm_mem_resp", bus4.mem_resp, 0);
        checkOutput("wm_pmem_write_chk", bus4.pmem_write, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0, 0);
        checkOutput("wb_pmem_write", bus4.pmem_write, 1);
        checkOutput("wb_pmem_addr_sel", bus4.pmem_addr_sel, 0);
        checkOutput("wb_pmem_read", bus4.pmem_read, 0);
        checkOutput("wb_ld_dirty_wait", bus4.ld_dirty, 0);
        applyStimulus(0, 1, 0, 1, 0, 4'd0, 4'd0, 0);
        checkOutput("wb_ld_dirty", bus4.ld_dirty, 4'b1000);
        checkOutput("wb_dirty_in", bus4.dirty_in, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0, 0);
        checkOutput("fill_pmem_read", bus4.pmem_read, 1);
        checkOutput("fill_pmem_write", bus4.pmem_write, 0);
        checkOutput("fill_data_in_sel", bus4.data_in_sel, 0);
        checkOutput("fill_data_we_wait", bus4.data_we, 0);
        applyStimulus(0, 1, 0, 1, 0, 4'd0, 4'd0, 0);
        checkOutput("fill_data_we", bus4.data_we, 4'b1000);
        checkOutput("fill_mode", bus4.data_we_mode, 2'b01);
        checkOutput("fill_ld_tag", bus4.ld_tag, 4'b1000);
        checkOutput("fill_ld_valid", bus4.ld_valid, 4'b1000);
        checkOutput("fill_valid_in", bus4.valid_in, 1);
        checkOutput("fill_mem_resp", bus4.mem_resp, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 1, 4'd3, 4'd0, 0);
        checkOutput("wh_data_we", bus4.data_we, 4'b1000);
        checkOutput("wh_mode", bus4.data_we_mode, 2'b10);
        checkOutput("wh_dirty_in", bus4.dirty_in, 1);
        checkOutput("wh_ld_dirty", bus4.ld_dirty, 4'b1000);
        checkOutput("wh_mem_resp", bus4.mem_resp, 1);
        checkOutput("wh_data_in_sel", bus4.data_in_sel, 1);
        checkOutput("wh8_data_we", bus8.data_we, 8'b0000_1000);
        tick();

        // Simultaneous demand and prefetch; prefetch then hits
        applyStimulus(1, 0, 1, 0, 1, 4'd0, 4'd0, 0);
        checkOutput("pri_mem_resp", bus4.mem_resp, 1);
        checkOutput("pri_pf_ack", bus4.pf_ack, 0);
        checkOutput("pri_addr_src", bus4.addr_src, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd0, 0);
        checkOutput("pri_pf_ack_late", bus4.pf_ack, 0);
        tick();
        checkOutput("pfh_pf_ack", bus4.pf_ack, 1);
        checkOutput("pfh_addr_src", bus4.addr_src, 1);
        checkOutput("pfh_pmem_read", bus4.pmem_read, 0);
        checkOutput("pfh_ld_lru", bus4.ld_lru, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 4'd1, 4'd0, 0);
        checkOutput("pfh_back_addr_src", bus4.addr_src, 0);
        checkOutput("pfh_back_pf_ack", bus4.pf_ack, 0);
        checkOutput("pfh_back_mem_resp", bus4.mem_resp, 1);
        tick();

        // Prefetch miss, clean victim 1; demand arrives during fill and waits
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd1, 0);
        tick();
        checkOutput("pfm_pf_ack", bus4.pf_ack, 1);
        checkOutput("pfm_addr_src", bus4.addr_src, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd2, 0);
        checkOutput("pff_pmem_read", bus4.pmem_read, 1);
        checkOutput("pff_addr_src", bus4.addr_src, 1);
        checkOutput("pff_mem_resp_wait", bus4.mem_resp, 0);
        checkOutput("pff_pf_ack", bus4.pf_ack, 0);
        applyStimulus(1, 0, 0, 1, 0, 4'd0, 4'd2, 0);
        checkOutput("pff_pf_done", bus4.pf_done, 1);
        checkOutput("pff_ld_valid", bus4.ld_valid, 4'b0010);
        checkOutput("pff_ld_lru", bus4.ld_lru, 0);
        checkOutput("pff_mem_resp", bus4.mem_resp, 0);
        checkOutput("pffu_ld_lru", bus4u.ld_lru, 1);
        checkOutput("pffu_lru_way", bus4u.lru_way, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 4'd1, 4'd0, 0);
        checkOutput("pff_after_mem_resp", bus4.mem_resp, 1);
        checkOutput("pff_after_pf_done", bus4.pf_done, 0);
        tick();

        // Reset in the middle of a fill
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd2, 0);
        tick();
        checkOutput("rf_pmem_read", bus4.pmem_read, 1);
        rst = 1'b1;
        applyStimulus(1, 0, 0, 1, 0, 4'd0, 4'd2, 0);
        checkOutput("rf_rst_pmem_read", bus4.pmem_read, 0);
        checkOutput("rf_rst_data_we", bus4.data_we, 0);
        checkOutput("rf_rst_data_in_sel", bus4.data_in_sel, 1);
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd0, 0);
        checkOutput("rf_post_pmem_read", bus4.pmem_read, 0);
        checkOutput("rf_post_data_we", bus4.data_we, 0);
        checkOutput("rf_post_ld_valid", bus4.ld_valid, 0);
        tick();

        // 8-way regression: read hit way 7, write miss to dirty victim 7, write hit
        applyStimulus(1, 0, 0, 0, 1, 4'd7, 4'd0, 0);
        checkOutput("w8_rh_mem_resp", bus8.mem_resp, 1);
        checkOutput("w8_rh_lru_way", bus8.lru_way, 7);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd7, 1);
        tick();
        applyStimulus(0, 1, 0, 1, 0, 4'd0, 4'd0, 0);
        checkOutput("w8_wb_pmem_write", bus8.pmem_write, 1);
        checkOutput("w8_wb_ld_dirty", bus8.ld_dirty, 8'b1000_0000);
        tick();
        applyStimulus(0, 1, 0, 1, 0, 4'd0, 4'd0, 0);
        checkOutput("w8_fill_data_we", bus8.data_we, 8'b1000_0000);
        checkOutput("w8_fill_ld_tag", bus8.ld_tag, 8'b1000_0000);
        checkOutput("w8_fill_mode", bus8.data_we_mode, 2'b01);
        tick();
        applyStimulus(0, 1, 0, 0, 1, 4'd7, 4'd0, 0);
        checkOutput("w8_wh_data_we", bus8.data_we, 8'b1000_0000);
        checkOutput("w8_wh_mode", bus8.data_we_mode, 2'b10);
        checkOutput("w8_wh_mem_resp", bus8.mem_resp, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
